// File: rtl/display_select.sv
// Debug display front-end: debounced mode button selects pc / aux / frozen pc for the display.
// Optional macro DISPLAY_SELECT_HALT_FREEZE_EN: show pc captured at halt while the CPU is halted.
module display_select #(
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned BLINK_BITS    = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] pc,
    input  logic [13:0] aux,
    input  logic        halted,
    input  logic        button,
    output logic [13:0] disp_pc,
    output logic [3:0]  disp_dots
);

    typedef enum logic [1:0] {
        MODE_PC     = 2'd0,
        MODE_AUX    = 2'd1,
        MODE_FREEZE = 2'd2
    } mode_t;

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_db;
    logic                     r_db_prev;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic [1:0]               r_warm;
    logic                     r_armed;
    logic [BLINK_BITS-1:0]    r_blink;
    logic [13:0]              r_freeze;
    mode_t                    r_mode;
    mode_t                    w_mode_next;
    logic                     w_press;
    logic                     w_enter_freeze;
    logic [13:0]              w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == '1) begin
            r_db     <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Presses arm only once a genuine post-reset low has passed the synchronizer,
    // so a button held through reset cannot fire when reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm    <= '0;
            r_armed   <= 1'b0;
            r_db_prev <= 1'b0;
        end else begin
            r_warm    <= {r_warm[0], 1'b1};
            r_db_prev <= r_db;
            if (r_warm[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_press = r_db & ~r_db_prev & r_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= MODE_PC;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_PC:     if (w_press) w_mode_next = MODE_AUX;
            MODE_AUX:    if (w_press) w_mode_next = MODE_FREEZE;
            MODE_FREEZE: if (w_press) w_mode_next = MODE_PC;
            default:     w_mode_next = w_press ? MODE_AUX : MODE_PC;
        endcase
    end

    assign w_enter_freeze = (w_mode_next == MODE_FREEZE) && (r_mode != MODE_FREEZE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_freeze <= '0;
        end else if (w_enter_freeze) begin
            r_freeze <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

`ifdef DISPLAY_SELECT_HALT_FREEZE_EN
    logic        r_halted_prev;
    logic [13:0] r_halt_pc;
    logic        w_halt_rise;
    logic [13:0] w_halt_word;

    assign w_halt_rise = halted & ~r_halted_prev;
    // On the halt edge itself the register is still loading, so forward pc.
    assign w_halt_word = w_halt_rise ? pc : r_halt_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted_prev <= 1'b0;
            r_halt_pc     <= '0;
        end else begin
            r_halted_prev <= halted;
            if (w_halt_rise) begin
                r_halt_pc <= pc;
            end
        end
    end
`endif

    always_comb begin
        w_sel = pc;
        case (r_mode)
            MODE_PC:     w_sel = pc;
            MODE_AUX:    w_sel = aux;
            MODE_FREEZE: w_sel = r_freeze;
            default:     w_sel = pc;
        endcase
`ifdef DISPLAY_SELECT_HALT_FREEZE_EN
        if (halted) begin
            w_sel = w_halt_word;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_pc   <= '0;
            disp_dots <= '0;
        end else begin
            disp_pc   <= w_sel;
            disp_dots <= {r_blink[BLINK_BITS-1], halted, r_mode};
        end
    end

endmodule

// File: tb/tb_display_select.sv
// Scoreboard bench for display_select: a cycle-level reference model predicts every output word,
// a monitor process compares them after each rising edge.
module tb_display_select;

    localparam int DB = 4;
    localparam int BB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] pc;
    logic [13:0] aux;
    logic        halted;
    logic        button;
    logic [13:0] disp_pc;
    logic [3:0]  disp_dots;

    always #5 clk = ~clk;

    display_select #(
        .DEBOUNCE_BITS(DB),
        .BLINK_BITS(BB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .aux(aux),
        .halted(halted),
        .button(button),
        .disp_pc(disp_pc),
        .disp_dots(disp_dots)
    );

    typedef struct packed {
        logic [13:0] pc;
        logic [3:0]  dots;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state: button history (2 = unknown level seeded by reset),
    // debounced level, length of current disagreement run, mode as 0/1/2.
    int          hist[$];
    int          m_db, m_run, m_armed, m_pending, m_mode, m_hb, m_hprev;
    logic [13:0] m_freeze, m_halt;

    task automatic model_step(output exp_t e);
        int          s;
        int          lvl;
        int          adv;
        logic [13:0] sel;
        if (reset) begin
            hist = '{2, 2};
            m_db = 0; m_run = 0; m_armed = 0; m_pending = 0;
            m_mode = 0; m_hb = 0; m_hprev = 0;
            m_freeze = '0; m_halt = '0;
            e = '0;
            return;
        end
        if (m_mode == 0)      sel = pc;
        else if (m_mode == 1) sel = aux;
        else                  sel = m_freeze;
`ifdef DISPLAY_SELECT_HALT_FREEZE_EN
        if (halted && m_hprev == 0) m_halt = pc;
        if (halted) sel = m_halt;
        m_hprev = halted ? 1 : 0;
`endif
        e.pc   = sel;
        e.dots = {(m_hb >= (1 << (BB - 1))) ? 1'b1 : 1'b0, halted, 2'(m_mode)};
        m_hb   = (m_hb + 1) % (1 << BB);

        adv = m_pending;
        m_pending = 0;
        s = hist.pop_front();
        hist.push_back(button ? 1 : 0);
        if (s == 0) m_armed = 1;
        lvl = (s == 1) ? 1 : 0;
        if (lvl != m_db) begin
            m_run++;
            if (m_run == (1 << DB)) begin
                m_db = lvl;
                m_run = 0;
                if (m_db == 1 && m_armed == 1) m_pending = 1;
            end
        end else begin
            m_run = 0;
        end
        if (adv == 1) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 2) m_freeze = pc;
        end
    endtask

    // Push the prediction for the coming rising edge, then wait to just after the next falling edge.
    task automatic tick();
        exp_t e;
        model_step(e);
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_const(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (disp_pc !== e.pc) begin
                    errors++;
                    $display("FAIL disp_pc: got %h expected %h (cycle %0d)", disp_pc, e.pc, cycle);
                end
                checks++;
                if (disp_dots !== e.dots) begin
                    errors++;
                    $display("FAIL disp_dots: got %b expected %b (cycle %0d)", disp_dots, e.dots, cycle);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int hold;
        int rst_left;
        reset = 1'b1; pc = '0; aux = '0; halted = 1'b0; button = 1'b0;
        ticks(3);
        check_const("reset_pc", disp_pc, 14'h0000);
        check_const("reset_dots", 14'(disp_dots), 14'h0000);

        reset = 1'b0;
        pc = 14'h0123;
        tick();
        check_const("pc_follow", disp_pc, 14'h0123);
        ticks(12);

        button = 1'b1; ticks(5);
        button = 1'b0; ticks(25);
        check_const("short_pulse_mode", 14'(disp_dots[1:0]), 14'd0);

        button = 1'b1; ticks(15);
        button = 1'b0; ticks(25);
        check_const("pulse15_mode", 14'(disp_dots[1:0]), 14'd0);

        aux = 14'h2AAA;
        button = 1'b1; ticks(30);
        button = 1'b0; ticks(20);
        check_const("aux_mode", 14'(disp_dots[1:0]), 14'd1);
        check_const("aux_value", disp_pc, 14'h2AAA);

        pc = 14'h0040;
        button = 1'b1; ticks(20);
        button = 1'b0; ticks(3);
        pc = 14'h0050; ticks(17);
        check_const("freeze_mode", 14'(disp_dots[1:0]), 14'd2);
        check_const("freeze_hold", disp_pc, 14'h0040);
        button = 1'b1; ticks(20);
        button = 1'b0; ticks(20);
        check_const("wrap_mode", 14'(disp_dots[1:0]), 14'd0);
        check_const("wrap_pc", disp_pc, 14'h0050);

        pc = 14'h0777; halted = 1'b1; tick();
        pc = 14'h0100; ticks(3);
        check_const("halt_dot", 14'(disp_dots[2]), 14'd1);
`ifdef DISPLAY_SELECT_HALT_FREEZE_EN
        check_const("halt_pc", disp_pc, 14'h0777);
`else
        check_const("halt_pc", disp_pc, 14'h0100);
`endif
        halted = 1'b0; ticks(4);

        button = 1'b1; ticks(8);
        reset = 1'b1; ticks(2);
        check_const("midreset_pc", disp_pc, 14'h0000);
        check_const("midreset_dots", 14'(disp_dots), 14'h0000);
        reset = 1'b0; ticks(40);
        check_const("held_through_reset", 14'(disp_dots[1:0]), 14'd0);
        button = 1'b0; ticks(25);
        button = 1'b1; ticks(25);
        check_const("rearm_press", 14'(disp_dots[1:0]), 14'd1);
        button = 1'b0; ticks(25);

        hold = 0;
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            pc  = 14'($urandom);
            aux = 14'($urandom);
            if ($urandom_range(49, 0) == 0) halted = ~halted;
            if (hold == 0) begin
                button = ~button;
                hold = $urandom_range(40, 1);
            end
            hold--;
            if (rst_left == 0 && $urandom_range(499, 0) == 0) rst_left = $urandom_range(3, 1);
            reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            tick();
        end
        reset = 1'b0;
        ticks(2);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
